// File: rtl/omem_readback_dma_pkg.sv
// rtl/omem_readback_dma_pkg.sv - shared widths, state encoding and core-search helper for the OMEM readback DMA
package omem_readback_dma_pkg;

  localparam int WB_WIDTH      = 32;
  localparam int MAX_CORES     = 4;
  localparam int MAX_CORE_BITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RENDER,
    READ,
    DRAIN,
    FINISH
  } dmaState;

  // Lowest set mask bit at index >= from; result is {found, index}.
  function automatic logic [MAX_CORE_BITS:0] findCore(input logic [MAX_CORES-1:0] mask,
                                                      input int from);
    logic [MAX_CORE_BITS:0] res;
    res = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) res = {1'b1, i[MAX_CORE_BITS-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/omem_readback_dma_stream_fifo.sv
// rtl/omem_readback_dma_stream_fifo.sv - show-ahead FIFO buffering readback beats ahead of the stream port
module omem_stream_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPop;

  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  // Storage array; written whenever a beat arrives and no flush is in progress.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= pushData;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push minus pop.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push)  wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({push, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/omem_readback_dma.sv
// rtl/omem_readback_dma.sv - sweeps enabled OMEM banks after render done and streams tagged words out
module omem_readback_dma
  import omem_readback_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     START_I,
  input  logic                     ABORT_I,
  input  logic [WB_WIDTH-1:0]      LEN_I,
  input  logic [MAX_CORES-1:0]     CMASK_I,
  input  logic                     RDONE_I,
  output logic [MAX_CORE_BITS-1:0] OMBSEL_O,
  output logic [WB_WIDTH-1:0]      OMADR_O,
  input  logic [WB_WIDTH-1:0]      OMEM_I,
  output logic [WB_WIDTH-1:0]      DAT_O,
  output logic [MAX_CORE_BITS-1:0] TAG_O,
  output logic [WB_WIDTH-1:0]      IDX_O,
  output logic                     VLD_O,
  input  logic                     RDY_I,
  output logic                     BUSY_O,
  output logic                     DONE_O
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int FW = MAX_CORE_BITS + WB_WIDTH + WB_WIDTH;

  dmaState                  state, stateNext;
  logic [WB_WIDTH-1:0]      lenReg, addr, inflAddr, lastAdr;
  logic [MAX_CORES-1:0]     maskReg;
  logic [MAX_CORE_BITS-1:0] corePtr, inflCore, lastSel;
  logic                     inflight;
  logic [CW:0]              fifoCount;
  logic                     fifoEmpty;
  logic [FW-1:0]            fifoOut;
  logic [CW+1:0]            occupancy, limit;
  logic [MAX_CORE_BITS:0]   firstHit, nextHit;
  logic                     pop, issue, abortHit, lastAddr, emptyJob;

  assign abortHit  = ABORT_I && (state != IDLE);
  assign firstHit  = findCore(maskReg, 0);
  assign nextHit   = findCore(maskReg, int'(corePtr) + 1);
  assign lastAddr  = (addr == lenReg - WB_WIDTH'(1));
  assign emptyJob  = (maskReg == '0) || (lenReg == '0);
  assign pop       = VLD_O && RDY_I;
  // Reads in flight plus buffered beats must still fit once this cycle's pop leaves.
  assign occupancy = {1'b0, fifoCount} + (CW + 2)'(inflight);
  assign limit     = (CW + 2)'(FIFO_DEPTH) + (CW + 2)'(pop);
  assign issue     = (state == READ) && !abortHit && (occupancy < limit);

  assign OMBSEL_O = issue ? corePtr : lastSel;
  assign OMADR_O  = issue ? addr : lastAdr;
  assign VLD_O    = !fifoEmpty;
  assign {TAG_O, IDX_O, DAT_O} = VLD_O ? fifoOut : '0;
  assign BUSY_O   = (state != IDLE);
  assign DONE_O   = (state == FINISH);

  // State register.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; abort overrides every other transition outside IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:        if (START_I) stateNext = WAIT_RENDER;
      WAIT_RENDER: if (RDONE_I) stateNext = emptyJob ? FINISH : READ;
      READ:        if (issue && lastAddr && !nextHit[MAX_CORE_BITS]) stateNext = DRAIN;
      DRAIN:       if (!inflight && fifoEmpty) stateNext = FINISH;
      FINISH:      stateNext = IDLE;
      default:     stateNext = IDLE;
    endcase
    if (abortHit) stateNext = IDLE;
  end

  // Job parameters, sweep pointers and the one-deep read-return pipeline.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      lenReg   <= '0;
      maskReg  <= '0;
      corePtr  <= '0;
      addr     <= '0;
      inflight <= 1'b0;
      inflCore <= '0;
      inflAddr <= '0;
      lastSel  <= '0;
      lastAdr  <= '0;
    end else if (abortHit) begin
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == IDLE && START_I) begin
        lenReg  <= LEN_I;
        maskReg <= CMASK_I;
      end
      if (state == WAIT_RENDER && RDONE_I) begin
        corePtr <= firstHit[MAX_CORE_BITS-1:0];
        addr    <= '0;
      end
      if (issue) begin
        lastSel  <= corePtr;
        lastAdr  <= addr;
        inflCore <= corePtr;
        inflAddr <= addr;
        if (lastAddr) begin
          if (nextHit[MAX_CORE_BITS]) corePtr <= nextHit[MAX_CORE_BITS-1:0];
          addr <= '0;
        end else begin
          addr <= addr + WB_WIDTH'(1);
        end
      end
    end
  end

  omem_stream_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK_I),
    .rstN    (RST_I),
    .flush   (abortHit),
    .push    (inflight),
    .pushData({inflCore, inflAddr, OMEM_I}),
    .pop     (pop),
    .popData (fifoOut),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

endmodule

// File: tb/tb_omem_readback_dma.sv
// tb/tb_omem_readback_dma.sv - scoreboard bench for the OMEM readback DMA
module tb_omem_readback_dma;

  logic        clk = 1'b0;
  logic        RST_I = 1'b0;
  logic        START_I = 1'b0;
  logic        ABORT_I = 1'b0;
  logic [31:0] LEN_I = '0;
  logic [3:0]  CMASK_I = '0;
  logic        RDONE_I = 1'b0;
  logic [1:0]  OMBSEL_O;
  logic [31:0] OMADR_O;
  logic [31:0] OMEM_I = '0;
  logic [31:0] DAT_O;
  logic [1:0]  TAG_O;
  logic [31:0] IDX_O;
  logic        VLD_O;
  logic        RDY_I = 1'b1;
  logic        BUSY_O;
  logic        DONE_O;

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] idx;
    logic [31:0] dat;
  } beatT;

  beatT sb[$];
  int   cmps = 0;
  int   errs = 0;
  int   doneCount = 0;
  int   selBad = 0;
  int   rdyMode = 0;
  int   holdLow = 0;
  bit   sparseMode = 0;
  bit   prevStall = 0;
  beatT prevBeat;

  omem_readback_dma #(.FIFO_DEPTH(4)) dut (
    .CLK_I(clk), .RST_I(RST_I), .START_I(START_I), .ABORT_I(ABORT_I),
    .LEN_I(LEN_I), .CMASK_I(CMASK_I), .RDONE_I(RDONE_I),
    .OMBSEL_O(OMBSEL_O), .OMADR_O(OMADR_O), .OMEM_I(OMEM_I),
    .DAT_O(DAT_O), .TAG_O(TAG_O), .IDX_O(IDX_O), .VLD_O(VLD_O), .RDY_I(RDY_I),
    .BUSY_O(BUSY_O), .DONE_O(DONE_O)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memVal(input logic [1:0] c, input logic [31:0] a);
    return {4'hD, 2'b00, c, 8'h5A, a[15:0]};
  endfunction

  // Bank model: synchronous read, data valid one cycle after the address.
  always @(posedge clk) OMEM_I <= memVal(OMBSEL_O, OMADR_O);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready driver: forced-low hold, then always-high / random / held-low.
  always @(posedge clk) begin
    #1;
    if (holdLow > 0) begin
      RDY_I = 1'b0;
      holdLow--;
    end else begin
      case (rdyMode)
        1:       RDY_I = 1'($urandom_range(0, 1));
        2:       RDY_I = 1'b0;
        default: RDY_I = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
  always @(negedge clk) begin
    beatT exp;
    if (!RST_I) begin
      prevStall = 0;
    end else begin
      if (DONE_O) doneCount++;
      if (sparseMode && (OMBSEL_O == 2'd0 || OMBSEL_O == 2'd2)) selBad++;
      if (prevStall) begin
        check("stall_vld", 64'(VLD_O), 64'd1);
        check("stall_idx", {30'd0, TAG_O, IDX_O}, {30'd0, prevBeat.tag, prevBeat.idx});
        check("stall_dat", 64'(DAT_O), 64'(prevBeat.dat));
      end
      if (VLD_O && RDY_I) begin
        if (sb.size() == 0) begin
          cmps++;
          errs++;
          $display("FAIL unexpected_beat: got tag %0d idx %0d, none expected", TAG_O, IDX_O);
        end else begin
          exp = sb.pop_front();
          check("beat_tag", 64'(TAG_O), 64'(exp.tag));
          check("beat_idx", 64'(IDX_O), 64'(exp.idx));
          check("beat_dat", 64'(DAT_O), 64'(exp.dat));
        end
      end
      prevStall = VLD_O && !RDY_I && !ABORT_I;
      prevBeat  = '{tag: TAG_O, idx: IDX_O, dat: DAT_O};
    end
  end

  task automatic pushExpected(input logic [31:0] len, input logic [3:0] mask);
    for (int c = 0; c < 4; c++)
      if (mask[c])
        for (int a = 0; a < int'(len); a++)
          sb.push_back('{tag: 2'(c), idx: 32'(a), dat: memVal(2'(c), 32'(a))});
  endtask

  task automatic startJob(input logic [31:0] len, input logic [3:0] mask);
    @(posedge clk); #1;
    START_I = 1'b1; LEN_I = len; CMASK_I = mask;
    @(posedge clk); #1;
    START_I = 1'b0;
  endtask

  task automatic runJob(input logic [31:0] len, input logic [3:0] mask, input int delay,
                        input bit chkLat, input int hold);
    int startDone;
    bit gotDone;
    pushExpected(len, mask);
    startDone = doneCount;
    gotDone = 0;
    startJob(len, mask);
    check("busy_after_start", 64'(BUSY_O), 64'd1);
    repeat (delay) @(posedge clk);
    #1;
    RDONE_I = 1'b1;
    holdLow = hold;
    for (int c = 0; c < 3000 && !gotDone; c++) begin
      @(negedge clk);
      if (chkLat && c == 2) check("latency_pre", 64'(VLD_O), 64'd0);
      if (chkLat && c == 3) check("latency_first", 64'(VLD_O), 64'd1);
      if (DONE_O) gotDone = 1;
    end
    check("done_seen", 64'(gotDone), 64'd1);
    RDONE_I = 1'b0;
    @(negedge clk);
    check("busy_fall", 64'(BUSY_O), 64'd0);
    check("done_once", 64'(doneCount - startDone), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic degenJob(input logic [31:0] len, input logic [3:0] mask);
    int startDone;
    startDone = doneCount;
    @(posedge clk); #1;
    RDONE_I = 1'b1; START_I = 1'b1; LEN_I = len; CMASK_I = mask;
    @(posedge clk); #1;
    START_I = 1'b0;
    @(negedge clk);
    check("degen_wait_done", 64'(DONE_O), 64'd0);
    check("degen_wait_busy", 64'(BUSY_O), 64'd1);
    @(negedge clk);
    check("degen_done", 64'(DONE_O), 64'd1);
    check("degen_no_vld", 64'(VLD_O), 64'd0);
    @(negedge clk);
    check("degen_idle_busy", 64'(BUSY_O), 64'd0);
    check("degen_done_once", 64'(doneCount - startDone), 64'd1);
    RDONE_I = 1'b0;
  endtask

  initial begin
    int startDone;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_vld", 64'(VLD_O), 64'd0);
    check("rst_busy", 64'(BUSY_O), 64'd0);
    check("rst_done", 64'(DONE_O), 64'd0);
    check("rst_sel_adr", {30'd0, OMBSEL_O, OMADR_O}, 64'd0);
    check("rst_stream", {30'd0, TAG_O, IDX_O}, 64'd0);
    @(posedge clk); #1;
    RST_I = 1'b1;

    // Basic sweep: all four cores, three words each.
    runJob(32'd3, 4'b1111, 5, 1'b1, 0);

    // Sparse mask: only cores 1 and 3 may ever be selected.
    sparseMode = 1;
    runJob(32'd2, 4'b1010, 2, 1'b1, 0);
    sparseMode = 0;
    check("sparse_sel", 64'(selBad), 64'd0);

    // Back-pressure: random ready with a 10-cycle hold-low at the start of READ.
    rdyMode = 1;
    runJob(32'd8, 4'b0100, 1, 1'b0, 10);
    rdyMode = 0;

    // Degenerate jobs.
    degenJob(32'd0, 4'b1111);
    degenJob(32'd5, 4'b0000);

    // Abort with three beats buffered and one read in flight.
    startDone = doneCount;
    rdyMode = 2;
    startJob(32'd8, 4'b0001);
    @(posedge clk); #1;
    RDONE_I = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_pre_vld", 64'(VLD_O), 64'd1);
    ABORT_I = 1'b1;
    @(posedge clk); #1;
    ABORT_I = 1'b0;
    RDONE_I = 1'b0;
    rdyMode = 0;
    @(negedge clk);
    check("abort_vld", 64'(VLD_O), 64'd0);
    check("abort_busy", 64'(BUSY_O), 64'd0);
    repeat (4) @(negedge clk);
    check("abort_no_done", 64'(doneCount - startDone), 64'd0);
    check("abort_stays_empty", 64'(VLD_O), 64'd0);
    runJob(32'd2, 4'b0100, 1, 1'b0, 0);

    // Asynchronous reset mid-READ.
    pushExpected(32'd8, 4'b1111);
    startJob(32'd8, 4'b1111);
    @(posedge clk); #1;
    RDONE_I = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    RST_I = 1'b0;
    #1;
    check("arst_vld", 64'(VLD_O), 64'd0);
    check("arst_busy", 64'(BUSY_O), 64'd0);
    check("arst_done", 64'(DONE_O), 64'd0);
    check("arst_sel_adr", {30'd0, OMBSEL_O, OMADR_O}, 64'd0);
    check("arst_stream", {30'd0, TAG_O, IDX_O}, 64'd0);
    check("arst_dat", 64'(DAT_O), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    RST_I = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", {62'd0, BUSY_O, VLD_O}, 64'd0);
    end
    RDONE_I = 1'b0;
    runJob(32'd3, 4'b1001, 2, 1'b1, 0);

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
